// File: rtl/ramdp_arbiter.sv
// Two-requester arbiter in front of a dual-port RAM (port A read/write, port B read-only).
// Grants up to two accesses per cycle, routes read data back, and can zero-fill the RAM after reset.
module ramdp_arbiter #(
    parameter int AddrSize     = 8,
    parameter int DataSize     = 8,
    parameter bit ClearOnReset = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    output logic                busy,
    input  logic                req0,
    input  logic                we0,
    input  logic [AddrSize-1:0] addr0_i,
    input  logic [DataSize-1:0] wdata0,
    output logic                ack0,
    output logic                rvalid0,
    output logic [DataSize-1:0] rdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [AddrSize-1:0] addr1_i,
    input  logic [DataSize-1:0] wdata1,
    output logic                ack1,
    output logic                rvalid1,
    output logic [DataSize-1:0] rdata1,
    output logic                ram_we,
    output logic [AddrSize-1:0] ram_addr0,
    output logic [AddrSize-1:0] ram_addr1,
    output logic [DataSize-1:0] ram_data_i,
    input  logic [DataSize-1:0] ram_data_o0,
    input  logic [DataSize-1:0] ram_data_o1
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam state_t              ResetState = ClearOnReset ? S_CLEAR : S_RUN;
    localparam logic [AddrSize-1:0] LastAddr   = '1;

    state_t                state_q, state_d;
    logic [AddrSize-1:0]   clr_cnt_q;
    logic                  prio_q;
    logic                  conflict;
    logic                  rvalid0_q, rvalid1_q;
    // Port-select per requester: 0 = read was issued on port A, 1 = on port B.
    logic                  rsel0_q, rsel1_q;
    logic                  sel0_d, sel1_d;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        ack0       = 1'b0;
        ack1       = 1'b0;
        ram_we     = 1'b0;
        ram_addr0  = '0;
        ram_addr1  = '0;
        ram_data_i = '0;
        sel0_d     = 1'b0;
        sel1_d     = 1'b0;
        conflict   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr0 = clr_cnt_q;
                if (clr_cnt_q == LastAddr) state_d = S_RUN;
            end
            S_RUN: begin
                if (req0 && req1) begin
                    if (we0 && we1) begin
                        conflict = 1'b1;
                        ram_we   = 1'b1;
                        if (prio_q) begin
                            ack1       = 1'b1;
                            ram_addr0  = addr1_i;
                            ram_data_i = wdata1;
                        end else begin
                            ack0       = 1'b1;
                            ram_addr0  = addr0_i;
                            ram_data_i = wdata0;
                        end
                    end else if (we1) begin
                        // Requester 1 writes on port A; requester 0 reads on port B.
                        ack0       = 1'b1;
                        ack1       = 1'b1;
                        ram_we     = 1'b1;
                        ram_addr0  = addr1_i;
                        ram_data_i = wdata1;
                        ram_addr1  = addr0_i;
                        sel0_d     = 1'b1;
                    end else begin
                        ack0       = 1'b1;
                        ack1       = 1'b1;
                        ram_we     = we0;
                        ram_addr0  = addr0_i;
                        ram_data_i = we0 ? wdata0 : '0;
                        ram_addr1  = addr1_i;
                        sel1_d     = 1'b1;
                    end
                end else if (req0) begin
                    ack0       = 1'b1;
                    ram_we     = we0;
                    ram_addr0  = addr0_i;
                    ram_data_i = we0 ? wdata0 : '0;
                end else if (req1) begin
                    ack1       = 1'b1;
                    ram_we     = we1;
                    ram_addr0  = addr1_i;
                    ram_data_i = we1 ? wdata1 : '0;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ResetState;
            clr_cnt_q <= '0;
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rsel0_q   <= 1'b0;
            rsel1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
            if (conflict) prio_q <= ~prio_q;
            rvalid0_q <= ack0 & ~we0;
            rvalid1_q <= ack1 & ~we1;
            rsel0_q   <= sel0_d;
            rsel1_q   <= sel1_d;
        end
    end

    assign busy    = (state_q == S_CLEAR);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rsel0_q ? ram_data_o1 : ram_data_o0;
    assign rdata1  = rsel1_q ? ram_data_o1 : ram_data_o0;

endmodule

// File: tb/tb_ramdp_arbiter.sv
// Self-checking bench for ramdp_arbiter: behavioural dual-port RAM, directed vector table,
// hand sequences for clear timing, mid-clear reset and the no-clear build.
module tb_ramdp_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam bit Y  = 1'b1;
    localparam bit N  = 1'b0;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          busy;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0_i = '0, addr1_i = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_we;
    logic [AW-1:0] ram_addr0, ram_addr1;
    logic [DW-1:0] ram_data_i;
    logic [DW-1:0] ram_q0, ram_q1;

    logic          nc_busy, nc_ack0, nc_ack1, nc_rvalid0, nc_rvalid1, nc_ram_we;
    logic [DW-1:0] nc_rdata0, nc_rdata1, nc_ram_data_i;
    logic [AW-1:0] nc_ram_addr0, nc_ram_addr1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ramdp_arbiter #(.AddrSize(AW), .DataSize(DW), .ClearOnReset(1'b1)) dut (
        .clock(clock), .reset(reset), .busy(busy),
        .req0(req0), .we0(we0), .addr0_i(addr0_i), .wdata0(wdata0),
        .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1_i(addr1_i), .wdata1(wdata1),
        .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr0(ram_addr0), .ram_addr1(ram_addr1),
        .ram_data_i(ram_data_i), .ram_data_o0(ram_q0), .ram_data_o1(ram_q1)
    );

    // Build without clearing: requester 0 permanently reads address 3.
    ramdp_arbiter #(.AddrSize(AW), .DataSize(DW), .ClearOnReset(1'b0)) dut_nc (
        .clock(clock), .reset(reset), .busy(nc_busy),
        .req0(1'b1), .we0(1'b0), .addr0_i(4'h3), .wdata0(8'h00),
        .ack0(nc_ack0), .rvalid0(nc_rvalid0), .rdata0(nc_rdata0),
        .req1(1'b0), .we1(1'b0), .addr1_i(4'h0), .wdata1(8'h00),
        .ack1(nc_ack1), .rvalid1(nc_rvalid1), .rdata1(nc_rdata1),
        .ram_we(nc_ram_we), .ram_addr0(nc_ram_addr0), .ram_addr1(nc_ram_addr1),
        .ram_data_i(nc_ram_data_i), .ram_data_o0(8'h00), .ram_data_o1(8'h00)
    );

    // Behavioural dual-port RAM with registered read, read-before-write on port A.
    logic [DW-1:0] mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) mem[i] = 8'hFF;
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr0] <= ram_data_i;
        ram_q0 <= mem[ram_addr0];
        ram_q1 <= mem[ram_addr1];
    end

    typedef struct {
        bit          req0, we0;
        bit [AW-1:0] a0;
        bit [DW-1:0] d0;
        bit          req1, we1;
        bit [AW-1:0] a1;
        bit [DW-1:0] d1;
        bit          ack0, ack1, rwe;
        bit [AW-1:0] ra0, ra1;
        bit [DW-1:0] rdi;
        bit          rv0, rv1;
        bit [DW-1:0] rd0, rd1;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int k);
        vec_t v;
        v       = vecs[k];
        req0    = v.req0; we0 = v.we0; addr0_i = v.a0; wdata0 = v.d0;
        req1    = v.req1; we1 = v.we1; addr1_i = v.a1; wdata1 = v.d1;
        #1;
        check($sformatf("v%0d busy", k), 32'(busy), 32'(0));
        check($sformatf("v%0d ack0", k), 32'(ack0), 32'(v.ack0));
        check($sformatf("v%0d ack1", k), 32'(ack1), 32'(v.ack1));
        check($sformatf("v%0d ram_we", k), 32'(ram_we), 32'(v.rwe));
        check($sformatf("v%0d ram_addr0", k), 32'(ram_addr0), 32'(v.ra0));
        check($sformatf("v%0d ram_addr1", k), 32'(ram_addr1), 32'(v.ra1));
        check($sformatf("v%0d ram_data_i", k), 32'(ram_data_i), 32'(v.rdi));
        @(posedge clock);
        #1;
        check($sformatf("v%0d rvalid0", k), 32'(rvalid0), 32'(v.rv0));
        check($sformatf("v%0d rvalid1", k), 32'(rvalid1), 32'(v.rv1));
        if (v.rv0) check($sformatf("v%0d rdata0", k), 32'(rdata0), 32'(v.rd0));
        if (v.rv1) check($sformatf("v%0d rdata1", k), 32'(rdata1), 32'(v.rd1));
    endtask

    // Called just after reset release: expects 16 clear cycles then RUN.
    task automatic check_clear(input string tag);
        for (int i = 0; i < 2**AW; i++) begin
            check($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'(1));
            check($sformatf("%s ram_we c%0d", tag, i), 32'(ram_we), 32'(1));
            check($sformatf("%s ram_addr0 c%0d", tag, i), 32'(ram_addr0), 32'(i));
            check($sformatf("%s ram_addr1 c%0d", tag, i), 32'(ram_addr1), 32'(0));
            check($sformatf("%s ram_data_i c%0d", tag, i), 32'(ram_data_i), 32'(0));
            check($sformatf("%s ack0 c%0d", tag, i), 32'(ack0), 32'(0));
            check($sformatf("%s ack1 c%0d", tag, i), 32'(ack1), 32'(0));
            @(posedge clock);
            #1;
        end
        check({tag, " busy after clear"}, 32'(busy), 32'(0));
    endtask

    initial begin
        vecs[0]  = '{N,N,4'h0,8'h00, N,N,4'h0,8'h00, N,N,N,4'h0,4'h0,8'h00, N,N,8'h00,8'h00};
        vecs[1]  = '{Y,Y,4'h5,8'h3A, N,N,4'h0,8'h00, Y,N,Y,4'h5,4'h0,8'h3A, N,N,8'h00,8'h00};
        vecs[2]  = '{N,N,4'h0,8'h00, Y,N,4'h5,8'h00, N,Y,N,4'h5,4'h0,8'h00, N,Y,8'h00,8'h3A};
        vecs[3]  = '{N,N,4'h0,8'h00, Y,Y,4'h7,8'h55, N,Y,Y,4'h7,4'h0,8'h55, N,N,8'h00,8'h00};
        vecs[4]  = '{Y,Y,4'h7,8'h66, Y,N,4'h7,8'h00, Y,Y,Y,4'h7,4'h7,8'h66, N,Y,8'h00,8'h55};
        vecs[5]  = '{Y,N,4'h7,8'h00, N,N,4'h0,8'h00, Y,N,N,4'h7,4'h0,8'h00, Y,N,8'h66,8'h00};
        vecs[6]  = '{Y,Y,4'h1,8'hA1, N,N,4'h0,8'h00, Y,N,Y,4'h1,4'h0,8'hA1, N,N,8'h00,8'h00};
        vecs[7]  = '{N,N,4'h0,8'h00, Y,Y,4'h2,8'hB2, N,Y,Y,4'h2,4'h0,8'hB2, N,N,8'h00,8'h00};
        vecs[8]  = '{Y,N,4'h1,8'h00, Y,N,4'h2,8'h00, Y,Y,N,4'h1,4'h2,8'h00, Y,Y,8'hA1,8'hB2};
        vecs[9]  = '{Y,N,4'h2,8'h00, Y,Y,4'h1,8'hC3, Y,Y,Y,4'h1,4'h2,8'hC3, Y,N,8'hB2,8'h00};
        vecs[10] = '{Y,N,4'h1,8'h00, N,N,4'h0,8'h00, Y,N,N,4'h1,4'h0,8'h00, Y,N,8'hC3,8'h00};
        vecs[11] = '{Y,Y,4'h2,8'h11, Y,Y,4'h3,8'h22, Y,N,Y,4'h2,4'h0,8'h11, N,N,8'h00,8'h00};
        vecs[12] = '{N,N,4'h0,8'h00, Y,Y,4'h3,8'h22, N,Y,Y,4'h3,4'h0,8'h22, N,N,8'h00,8'h00};
        vecs[13] = '{Y,Y,4'h4,8'h33, Y,Y,4'h5,8'h44, N,Y,Y,4'h5,4'h0,8'h44, N,N,8'h00,8'h00};
        vecs[14] = '{Y,Y,4'h4,8'h33, N,N,4'h0,8'h00, Y,N,Y,4'h4,4'h0,8'h33, N,N,8'h00,8'h00};
        vecs[15] = '{Y,Y,4'h6,8'h55, Y,Y,4'h8,8'h66, Y,N,Y,4'h6,4'h0,8'h55, N,N,8'h00,8'h00};
        vecs[16] = '{Y,N,4'h2,8'h00, Y,N,4'h3,8'h00, Y,Y,N,4'h2,4'h3,8'h00, Y,Y,8'h11,8'h22};
        vecs[17] = '{Y,Y,4'h9,8'h77, Y,Y,4'hA,8'h88, N,Y,Y,4'hA,4'h0,8'h88, N,N,8'h00,8'h00};
        vecs[18] = '{Y,N,4'h4,8'h00, Y,N,4'h5,8'h00, Y,Y,N,4'h4,4'h5,8'h00, Y,Y,8'h33,8'h44};

        // Reset state, with requester 0 already waiting to read address 9.
        req0 = 1'b1; we0 = 1'b0; addr0_i = 4'h9;
        repeat (2) @(posedge clock);
        #1;
        check("reset busy", 32'(busy), 32'(1));
        check("reset ack0", 32'(ack0), 32'(0));
        check("reset rvalid0", 32'(rvalid0), 32'(0));
        check("reset rvalid1", 32'(rvalid1), 32'(0));
        check("nc reset busy", 32'(nc_busy), 32'(0));
        check("nc reset rvalid0", 32'(nc_rvalid0), 32'(0));
        reset = 1'b1;
        #1;
        check("nc first-cycle ack0", 32'(nc_ack0), 32'(1));
        check_clear("clear1");
        check("nc rvalid0", 32'(nc_rvalid0), 32'(1));
        check("pending ack0 after clear", 32'(ack0), 32'(1));
        check("pending ram_addr0", 32'(ram_addr0), 32'(9));
        @(posedge clock);
        #1;
        check("pending rvalid0", 32'(rvalid0), 32'(1));
        check("pending rdata0", 32'(rdata0), 32'(0));

        for (int k = 0; k < 19; k++) apply_vec(k);

        // Read acked, then reset right after its edge: the rvalid must vanish.
        req0 = 1'b1; we0 = 1'b0; addr0_i = 4'h1; req1 = 1'b0;
        #1;
        check("pre-reset ack0", 32'(ack0), 32'(1));
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid reset rvalid0", 32'(rvalid0), 32'(0));
        check("mid reset busy", 32'(busy), 32'(1));
        check("mid reset ack0", 32'(ack0), 32'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        check("clear count 6 addr", 32'(ram_addr0), 32'(6));
        reset = 1'b0;
        #1;
        check("clear abort busy", 32'(busy), 32'(1));
        check("clear abort addr", 32'(ram_addr0), 32'(0));
        check("clear abort ack0", 32'(ack0), 32'(0));
        check("clear abort rvalid0", 32'(rvalid0), 32'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_clear("clear2");
        check("post clear2 ack0", 32'(ack0), 32'(1));
        req0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ramdp_arbiter.md
Name: ramdp_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one dual-port RAM instance: port A is read/write, port B is read-only, and both have registered outputs with 1-cycle read latency.
- Grants up to two accesses per cycle, routes read data back to the issuing requester and resolves write-write conflicts round-robin.
- Optionally zero-fills the whole RAM after reset before accepting traffic.
- Sits between the RAM and two independent client blocks.

Parameters:
AddrSize, 8, RAM address width; depth = 2**AddrSize
DataSize, 8, RAM data width
ClearOnReset, 1, 1 = zero-fill RAM after reset; 0 = enter RUN directly

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
busy  out  1  high while clearing; no grants issued
req0  in  1  requester 0 access request; held until ack0
we0  in  1  requester 0: 1 = write, 0 = read
addr0_i  in  AddrSize  requester 0 address
wdata0  in  DataSize  requester 0 write data
ack0  out  1  requester 0 granted this cycle (combinational)
rvalid0  out  1  requester 0 read data valid
rdata0  out  DataSize  requester 0 read data
req1, we1, addr1_i, wdata1, ack1, rvalid1, rdata1: same as requester 0, for requester 1
ram_we  out  1  RAM port A write enable
ram_addr0  out  AddrSize  RAM port A address
ram_addr1  out  AddrSize  RAM port B address
ram_data_i  out  DataSize  RAM port A write data
ram_data_o0  in  DataSize  RAM port A registered read data
ram_data_o1  in  DataSize  RAM port B registered read data

Behaviour:
- States: CLEAR, RUN. While reset is low: state = CLEAR if ClearOnReset else RUN; clear counter = 0; prio = 0; rvalid0/1 = 0; rsel0/rsel1 (port-select flops) = 0.
- Reset values: busy = 1 if ClearOnReset else 0; ack0/ack1 = 0 in CLEAR; rdata0/1 undefined while rvalid low.
- CLEAR:
  - ram_we = 1, ram_addr0 = counter, ram_data_i = 0, ram_addr1 = 0.
  - Counter increments every cycle. On counter = 2**AddrSize-1 the write completes, next state is RUN and busy falls.
  - Clear lasts exactly 2**AddrSize cycles.
  - Requests are not acked during CLEAR and stay pending.
- RUN, per cycle, combinational grant and RAM drive. Idle outputs: ram_we = 0, addresses = 0, data = 0.
  - No request: nothing granted; RAM idle.
  - Single request: served on port A (read or write); ack asserted.
  - Both reads: req0 on port A, req1 on port B; both acked.
  - One write, one read: writer on port A, reader on port B; both acked. Same address: reader returns pre-write contents; no forwarding.
  - Both writes: requester with index == prio gets port A and ack; the other is not acked. prio := loser index after the conflict cycle. prio changes only on write-write conflicts.
- Read return:
  - A read acked in cycle N gives rvalidX = 1 in cycle N+1 for exactly one cycle.
  - rdataX = ram_data_o0 or ram_data_o1, selected by the port flop registered at cycle N.
  - Writes never assert rvalid. Port A read data during a write is ignored.
- Back-to-back: a requester may hold req high across cycles; each acked cycle is one access. Throughput is 1 access per requester per cycle except on write-write conflicts.
- Inputs sampled only in the ack cycle; the requester may change we/addr/wdata after ack.
- Reset asserted mid-operation: all flops return to reset values immediately. A pending rvalid is lost. An in-progress clear restarts from address 0 after reset release.

Test Plan:
- AddrSize=4, ClearOnReset=1, release reset -> busy high exactly 16 cycles, ram_we=1 with ram_addr0 0..15, ram_data_i=0; then req0 read addr 9 -> ack0 same cycle, rvalid0 next cycle with rdata0=0x00.
- RUN: req0 write 0x3A to addr 5; later req1 read addr 5 -> ack1, then rvalid1=1 with rdata1=0x3A via port A.
- Both write in same cycle (0x11@2 from req0, 0x22@3 from req1), requests held -> cycle 1: ack0 only; cycle 2: ack1; next conflict grants req1 first (prio=1).
- Addr 7 holds 0x55; req0 write 0x66@7 and req1 read @7 same cycle -> both acked, rdata1=0x55; a subsequent read of 7 returns 0x66.
- Both reads, addr 1 holding 0xA1 and addr 2 holding 0xB2 -> ram_addr0=1, ram_addr1=2, next cycle rvalid0 and rvalid1 both high, rdata0=0xA1, rdata1=0xB2.
- Assert reset at clear count 6 -> busy stays high, rvalid=0, ack=0; after release clear restarts at address 0 and takes 16 cycles; ClearOnReset=0 build -> busy=0, first req acked on the first cycle after reset release.
